if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and runs a req/ack handshake with instruction memory. It holds one fetched instruction plus its word-address PC+1 in an output buffer that the IF/ID register consumes. It also applies redirects (taken branch, j/jal, jalr) resolved in ID, discarding wrong-path fetches, including one still outstanding in memory.

---
 rtl/if_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, runs a req/ack handshake with instruction memory, holds one
// fetched instruction plus its PC+1 and applies redirects resolved in ID,
// dropping wrong-path data, including a fetch still pending in memory.
// Optional feature macro: IF_ALIGN_CHECK_EN (misaligned jalr traps to EXC_VECTOR).
module if_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        BranchBubble,
  input  logic        br_taken,
  input  logic [29:0] br_target,
  input  logic        jump,
  input  logic        jal,
  input  logic [25:0] j_index,
  input  logic [29:0] id_pc_plus_4,
  input  logic        jalr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [29:0] pc_plus_4,
  output logic        if_addr_err
);

`ifdef IF_ALIGN_CHECK_EN
  localparam logic [29:0] EXC_VECTOR = 30'h0000_1060;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [29:0] r_pc;
  logic [29:0] r_addr;
  logic [29:0] r_pc_plus_4;
  logic [31:0] r_ins;
  logic        r_valid;
  logic        r_hold;
  logic        r_addr_err;

  logic        w_stall;
  logic        w_advance;
  logic        w_redirect;
  logic [29:0] w_target;
  logic        w_misaligned;
  logic        w_req;
  logic        w_ack;
  logic        w_unused;

  assign w_stall    = hazard | BranchBubble;
  assign w_advance  = r_valid & ~w_stall;
  assign w_redirect = (br_taken | jump | jal | jalr) & ~w_stall;

`ifdef IF_ALIGN_CHECK_EN
  assign w_misaligned = jalr & (|jr_target[1:0]);
  assign w_unused     = ^id_pc_plus_4[25:0];
`else
  assign w_misaligned = 1'b0;
  assign w_unused     = ^{id_pc_plus_4[25:0], jr_target[1:0]};
`endif

  // Redirect target select: jalr, then j/jal, then conditional branch
  always_comb begin
    w_target = br_target;
    if (jalr) begin
`ifdef IF_ALIGN_CHECK_EN
      w_target = w_misaligned ? EXC_VECTOR : jr_target[31:2];
`else
      w_target = jr_target[31:2];
`endif
    end else if (jump | jal) begin
      w_target = {id_pc_plus_4[29:26], j_index};
    end
  end

  // A new request starts only when unstalled (buffer then is empty or
  // advancing); once raised it is held until ack. DROP always requests.
  assign w_req = (r_state == S_DROP) |
                 ((r_state == S_REQ) & (r_hold | ~w_stall));
  assign w_ack = w_req & imem_ack;

  assign imem_req    = w_req;
  assign imem_addr   = r_addr;
  assign if_valid    = r_valid;
  assign if_ins      = r_ins;
  assign pc_plus_4   = r_pc_plus_4;
  assign if_addr_err = r_addr_err;

  // Fetch FSM, PC, output buffer and address-error pulse.
  // In DROP, r_pc already holds the redirect target while r_addr keeps the
  // old address stable until the pending fetch is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_pc_plus_4 <= '0;
      r_ins       <= '0;
      r_valid     <= 1'b0;
      r_hold      <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_addr_err <= w_redirect & w_misaligned & (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_redirect) begin
            r_valid <= 1'b0;
            r_ins   <= '0;
            r_pc    <= w_target;
            if (w_req && !imem_ack) begin
              r_state <= S_DROP;
              r_hold  <= 1'b1;
            end else begin
              r_addr <= w_target;
              r_hold <= 1'b0;
            end
          end else if (w_ack) begin
            r_ins       <= imem_rdata;
            r_pc_plus_4 <= r_pc + 30'd1;
            r_valid     <= 1'b1;
            r_pc        <= r_pc + 30'd1;
            r_addr      <= r_pc + 30'd1;
            r_hold      <= 1'b0;
          end else begin
            if (w_advance) begin
              r_valid <= 1'b0;
              r_ins   <= '0;
            end
            if (w_req) begin
              r_hold <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (imem_ack) begin
            r_state <= S_REQ;
            r_hold  <= 1'b0;
            r_addr  <= w_redirect ? w_target : r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a variable-latency memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard, BranchBubble, br_taken, jump, jal, jalr;
  logic [29:0] br_target, id_pc_plus_4;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        imem_req, imem_ack;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid, if_addr_err;
  logic [31:0] if_ins;
  logic [29:0] pc_plus_4;

  int unsigned wait_cycles;
  int unsigned wcnt;
  int          vectors = 0;
  int          errors  = 0;

  logic [94:0] obs;
  logic [94:0] e;

  if_fetch_unit #(.RESET_PC(30'h0000_0C00)) dut (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .BranchBubble(BranchBubble),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jal(jal),
    .j_index(j_index), .id_pc_plus_4(id_pc_plus_4), .jalr(jalr),
    .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ins(if_ins), .pc_plus_4(pc_plus_4), .if_addr_err(if_addr_err)
  );

  always #5 clk = ~clk;

  // Memory: acks after wait_cycles request cycles; data tags the address
  assign imem_ack   = imem_req && (wcnt >= wait_cycles);
  assign imem_rdata = (imem_addr == 30'h0C00) ? 32'h2408_0001 : {2'b10, imem_addr};

  always_ff @(posedge clk) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign obs = {imem_req, imem_addr, if_valid, if_ins, pc_plus_4, if_addr_err};

  function automatic logic [94:0] ex(input logic req, input logic [29:0] addr,
                                     input logic v, input logic [31:0] ins,
                                     input logic [29:0] p4, input logic err);
    return {req, addr, v, ins, p4, err};
  endfunction

  task automatic clear_inputs();
    hazard = 0; BranchBubble = 0; br_taken = 0; jump = 0; jal = 0; jalr = 0;
    br_target = '0; id_pc_plus_4 = '0; j_index = '0; jr_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (IDLE) after reset release
  task automatic do_reset(input int unsigned w);
    clear_inputs();
    wait_cycles = w;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    wait_cycles = 0;
    rst_n = 0;
    step();
    #1;
    e = ex(0, 30'h0C00, 0, 32'h0, 30'h0, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL reset_held got=%h exp=%h", obs, e); end
    step();
    rst_n = 1;
    #1;
    e = ex(0, 30'h0C00, 0, 32'h0, 30'h0, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    step(); #1;
    e = ex(1, 30'h0C00, 0, 32'h0, 30'h0, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL zw_c1 got=%h exp=%h", obs, e); end
    step(); #1;
    e = ex(1, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL zw_c2 got=%h exp=%h", obs, e); end
    step(); #1;
    e = ex(1, 30'h0C02, 1, 32'h8000_0C01, 30'h0C02, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL zw_c3 got=%h exp=%h", obs, e); end
    step(); #1;
    e = ex(1, 30'h0C03, 1, 32'h8000_0C02, 30'h0C03, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL zw_c4 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_wait_states();
    do_reset(3);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      e = ex(1, 30'h0C00, 0, 32'h0, 30'h0, 0); vectors++;
      if (obs !== e) begin errors++; $display("FAIL ws_hold_c%0d got=%h exp=%h", i, obs, e); end
    end
    step(); #1;
    e = ex(1, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL ws_data got=%h exp=%h", obs, e); end
  endtask

  task automatic test_stall();
    do_reset(0);
    step();
    step();
    hazard = 1; #1;
    e = ex(0, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL st_hazard got=%h exp=%h", obs, e); end
    step();
    hazard = 0; BranchBubble = 1; #1;
    e = ex(0, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL st_bubble got=%h exp=%h", obs, e); end
    step();
    BranchBubble = 0; #1;
    e = ex(1, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL st_resume got=%h exp=%h", obs, e); end
    step(); #1;
    e = ex(1, 30'h0C02, 1, 32'h8000_0C01, 30'h0C02, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL st_next got=%h exp=%h", obs, e); end
  endtask

  // Branch while a 2-wait fetch of 0C01 is pending; optionally re-redirect in DROP
  task automatic test_drop(input logic ovw, input logic [29:0] t,
                           input logic [31:0] tins, input logic [29:0] t1);
    do_reset(2);
    step(); step(); step();
    step();
    br_taken = 1; br_target = 30'h0D00; #1;
    e = ex(1, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL dr_pre got=%h exp=%h", obs, e); end
    step();
    br_taken = ovw; br_target = 30'h0E00; #1;
    e = ex(1, 30'h0C01, 0, 32'h0, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL dr_drop1 got=%h exp=%h", obs, e); end
    step();
    br_taken = 0; #1;
    e = ex(1, 30'h0C01, 0, 32'h0, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL dr_drop2 got=%h exp=%h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      e = ex(1, t, 0, 32'h0, 30'h0C01, 0); vectors++;
      if (obs !== e) begin errors++; $display("FAIL dr_target_c%0d got=%h exp=%h", i, obs, e); end
    end
    step(); #1;
    e = ex(1, t1, 1, tins, t1, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL dr_data got=%h exp=%h", obs, e); end
  endtask

  task automatic test_jump();
    do_reset(0);
    step();
    step();
    jal = 1; j_index = 26'h000_0100; id_pc_plus_4 = 30'h0000_0C05;
    br_taken = 1; br_target = 30'h0D00; #1;
    e = ex(1, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL jal_pre got=%h exp=%h", obs, e); end
    step();
    clear_inputs(); #1;
    e = ex(1, 30'h0100, 0, 32'h0, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL jal_addr got=%h exp=%h", obs, e); end
    step();
    jump = 1; j_index = 26'h000_0040; id_pc_plus_4 = 30'h2000_0000; #1;
    e = ex(1, 30'h0101, 1, 32'h8000_0100, 30'h0101, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL jal_data got=%h exp=%h", obs, e); end
    step();
    clear_inputs(); #1;
    e = ex(1, 30'h2000_0040, 0, 32'h0, 30'h0101, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL j_upper got=%h exp=%h", obs, e); end
  endtask

  task automatic test_jalr_align();
    logic [29:0] p4;
    do_reset(0);
    step();
    step();
    jalr = 1; jr_target = 32'h0000_3002;
    step();
    clear_inputs(); #1;
`ifdef IF_ALIGN_CHECK_EN
    e = ex(1, 30'h1060, 0, 32'h0, 30'h0C01, 1);
`else
    e = ex(1, 30'h0C00, 0, 32'h0, 30'h0C01, 0);
`endif
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL jalr_mis got=%h exp=%h", obs, e); end
    step();
    jalr = 1; jr_target = 32'h0000_5000; jump = 1; j_index = 26'h3;
    br_taken = 1; br_target = 30'h0D00; #1;
`ifdef IF_ALIGN_CHECK_EN
    p4 = 30'h1061;
    e = ex(1, 30'h1061, 1, 32'h8000_1060, 30'h1061, 0);
`else
    p4 = 30'h0C01;
    e = ex(1, 30'h0C01, 1, 32'h2408_0001, 30'h0C01, 0);
`endif
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL jalr_after got=%h exp=%h", obs, e); end
    step();
    clear_inputs(); #1;
    e = ex(1, 30'h1400, 0, 32'h0, p4, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL jalr_prio got=%h exp=%h", obs, e); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    step();
    step();
    jalr = 1; jr_target = 32'hFFFF_FFFC;
    step();
    clear_inputs(); #1;
    e = ex(1, 30'h3FFF_FFFF, 0, 32'h0, 30'h0C01, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL wrap_addr got=%h exp=%h", obs, e); end
    step(); #1;
    e = ex(1, 30'h0, 1, 32'hBFFF_FFFF, 30'h0, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL wrap_data got=%h exp=%h", obs, e); end
    step(); #1;
    e = ex(1, 30'h1, 1, 32'h8000_0000, 30'h1, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL wrap_next got=%h exp=%h", obs, e); end
  endtask

  task automatic test_async_reset();
    do_reset(0);
    step(); step(); step();
    wait_cycles = 5; #1;
    e = ex(1, 30'h0C02, 1, 32'h8000_0C01, 30'h0C02, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL ar_pending got=%h exp=%h", obs, e); end
    #1 rst_n = 0;
    #1;
    e = ex(0, 30'h0C00, 0, 32'h0, 30'h0, 0); vectors++;
    if (obs !== e) begin errors++; $display("FAIL ar_async got=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_drop(1'b0, 30'h0D00, 32'h8000_0D00, 30'h0D01);
    test_drop(1'b1, 30'h0E00, 32'h8000_0E00, 30'h0E01);
    test_jump();
    test_jalr_align();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
